// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter that lets one of NUM_REQ requesters drive a shared enabled register,
// limiting each grant to MAX_BURST write cycles.
module dff_write_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 1,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned IdxW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CntW     = $clog2(MAX_BURST + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  din,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [IdxW-1:0]            owner,
  output logic                       busy,
  output logic                       reg_ena,
  output logic [DATA_W-1:0]          reg_din
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IdxW-1:0]    owner_q;
  logic [IdxW-1:0]    ptr_q;
  logic [CntW-1:0]    burst_cnt_q;
  logic               busy_q;

  logic               pick_valid;
  logic [IdxW-1:0]    pick_idx;
  logic               owner_req;
  logic               last_write;
  logic [IdxW-1:0]    next_ptr;

  // First requester at or after ptr_q, wrapping around.
  always_comb begin
    int unsigned cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQ;
      if (!pick_valid && req[IdxW'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    owner_req  = req[owner_q];
    last_write = owner_req && (burst_cnt_q == CntW'(MAX_BURST - 1));
    next_ptr   = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      burst_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q     <= StGrant;
            gnt_q       <= NUM_REQ'(1) << pick_idx;
            owner_q     <= pick_idx;
            burst_cnt_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        StGrant: begin
          if (owner_req) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
          end
          // Release when the owner stops writing or has used up its burst.
          if (!owner_req || last_write) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= next_ptr;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign reg_ena = |(gnt_q & req);
  assign reg_din = busy_q ? din[owner_q*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Bench for dff_write_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_dff_write_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] din = '0;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         busy;
  logic         reg_ena;
  logic [0:0]   reg_din;

  logic         rst1 = 1'b0;
  logic [0:0]   req1 = 1'b0;
  logic [0:0]   din1 = 1'b0;
  logic [0:0]   gnt1;
  logic [0:0]   owner1;
  logic         busy1;
  logic         reg_ena1;
  logic [0:0]   reg_din1;

  always #5 clk = ~clk;

  dff_write_arbiter #(.NUM_REQ(N), .DATA_W(1), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .owner(owner),
    .busy(busy), .reg_ena(reg_ena), .reg_din(reg_din)
  );

  dff_write_arbiter #(.NUM_REQ(1), .DATA_W(1), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst1), .req(req1), .din(din1), .gnt(gnt1), .owner(owner1),
    .busy(busy1), .reg_ena(reg_ena1), .reg_din(reg_din1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ena_seen = 0;

  // Behavioural model: who owns the register, writes used so far, where the search starts.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  task automatic compare_model();
    logic [31:0] e_gnt;
    logic [31:0] e_din;
    logic [31:0] e_ena;
    e_gnt = m_busy ? (32'd1 << m_owner) : 32'd0;
    e_ena = (m_busy && req[m_owner]) ? 32'd1 : 32'd0;
    e_din = m_busy ? 32'(din[m_owner]) : 32'd0;
    check("gnt", 32'(gnt), e_gnt);
    check("busy", 32'(busy), 32'(m_busy));
    check("reg_ena", 32'(reg_ena), e_ena);
    check("reg_din", 32'(reg_din), e_din);
    if (m_busy) check("owner", 32'(owner), 32'(m_owner));
  endtask

  task automatic model_advance();
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!m_busy && req[(m_ptr + k) % N]) begin
          m_busy  = 1'b1;
          m_owner = (m_ptr + k) % N;
          m_cnt   = 0;
        end
      end
    end else if (req[m_owner] && m_cnt + 1 < MB) begin
      m_cnt++;
    end else begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % N;
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
    req = r;
    din = d;
    @(negedge clk);
    compare_model();
    if (reg_ena) ena_seen++;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '1;
    din = '1;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_reg_ena", 32'(reg_ena), 32'd0);
    check("rst_reg_din", 32'(reg_din), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int exp_own[5];
    logic [N-1:0] r;
    exp_own = '{0, 1, 2, 3, 0};
    model_reset();
    @(posedge clk);
    #1;

    // Sole requester 2: grant, four writes, one bubble, regrant.
    do_reset();
    step(4'b0100, 4'b0100);
    check("t1_gnt_first", 32'(gnt), 32'h4);
    ena_seen = 0;
    repeat (4) step(4'b0100, 4'b0100);
    check("t1_writes", 32'(ena_seen), 32'd4);
    check("t1_bubble_gnt", 32'(gnt), 32'd0);
    step(4'b0100, 4'b0100);
    check("t1_regrant", 32'(gnt), 32'h4);

    // All requesting: owners rotate 0,1,2,3,0.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      step(4'b1111, 4'($urandom));
      check("t2_owner", 32'(owner), 32'(exp_own[g]));
      ena_seen = 0;
      repeat (4) step(4'b1111, 4'($urandom));
      check("t2_writes", 32'(ena_seen), 32'd4);
      check("t2_released", 32'(busy), 32'd0);
    end

    // Owner 1 drops request after two writes.
    do_reset();
    step(4'b0010, 4'b0010);
    check("t3_owner1", 32'(owner), 32'd1);
    repeat (2) step(4'b1111, 4'($urandom));
    step(4'b1101, 4'b1111);
    check("t3_drop_gnt", 32'(gnt), 32'd0);
    step(4'b1101, 4'b1111);
    check("t3_next_gnt", 32'(gnt), 32'h4);

    // ptr=2 with req 1001: grant 3 then 0.
    do_reset();
    step(4'b0010, 4'b0000);
    step(4'b0000, 4'b0000);
    check("t4_idle", 32'(gnt), 32'd0);
    step(4'b1001, 4'b1000);
    check("t4_gnt3", 32'(gnt), 32'h8);
    req = 4'b1001;
    din = 4'b1000;
    #2;
    check("t4_din3", 32'(reg_din), 32'd1);
    repeat (4) step(4'b1001, 4'($urandom));
    step(4'b1001, 4'b0001);
    check("t4_owner0", 32'(owner), 32'd0);
    check("t4_gnt0", 32'(gnt), 32'h1);

    // Reset asserted during the second write of a burst.
    do_reset();
    step(4'b1111, 4'b1111);
    step(4'b1111, 4'b1111);
    req = 4'b1111;
    din = 4'b1111;
    #2;
    check("t5_writing", 32'(reg_ena), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_gnt", 32'(gnt), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_reg_ena", 32'(reg_ena), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(4'b1111, 4'b1111);
    check("t5_restart_gnt", 32'(gnt), 32'h1);

    // Single requester, single-write bursts: grant toggles.
    req1 = 1'b1;
    din1 = 1'b1;
    rst1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t6_gnt", 32'(gnt1), 32'(k % 2));
      check("t6_reg_ena", 32'(reg_ena1), 32'(k % 2));
      check("t6_reg_din", 32'(reg_din1), 32'(k % 2));
      @(posedge clk);
      #1;
    end

    // Random traffic with occasional asynchronous reset.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & 4'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        check("rand_rst_gnt", 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
      end
      step(r, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
